// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: saturating event counters for cycles, retirements,
// per-source stalls and icache refills, read back through a registered select port.
module pipe_perf_monitor #(
  parameter int CNT_W         = 32,
  parameter int NUM_STALL_SRC = 3,
  parameter int LAT_W         = 16,
  parameter int SEL_W         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_STALL_SRC-1:0] stall_req,
  input  logic                     icache_stall,
  input  logic                     retire_valid,
  input  logic [SEL_W-1:0]         rd_sel,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     overflow
);

  localparam int NUM_RD = 6 + NUM_STALL_SRC;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state, state_nxt, fsm_nxt;

  logic [CNT_W-1:0] cycles, retired, any_stall, misses, refill_cyc;
  logic [CNT_W-1:0] stall_cnt [NUM_STALL_SRC];
  logic [LAT_W-1:0] cur_lat, max_lat;

  logic [CNT_W-1:0] cycles_nxt, retired_nxt, any_stall_nxt, misses_nxt, refill_cyc_nxt;
  logic [CNT_W-1:0] stall_cnt_nxt [NUM_STALL_SRC];
  logic [LAT_W-1:0] cur_lat_nxt, max_lat_nxt;
  logic             overflow_nxt;
  logic [CNT_W-1:0] rd_next;
  logic [CNT_W-1:0] rd_vec [NUM_RD];

  logic miss_ev, refill_ev, lat_start, lat_inc, lat_done;
  logic [CNT_W:0] r_cyc, r_ret, r_any, r_miss, r_refill;
  logic [CNT_W:0] r_stall [NUM_STALL_SRC];
  logic           ovf_set;

  // MSB of the result flags an increment that would have wrapped; the count then holds.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (!inc) begin
      return {1'b0, v};
    end else if (&v) begin
      return {1'b1, v};
    end else begin
      return {1'b0, v + CNT_W'(1)};
    end
  endfunction

  // Refill FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Refill FSM next state and miss/latency event strobes.
  always_comb begin
    fsm_nxt   = state;
    miss_ev   = 1'b0;
    refill_ev = 1'b0;
    lat_start = 1'b0;
    lat_inc   = 1'b0;
    lat_done  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (icache_stall) begin
            fsm_nxt   = REFILL;
            miss_ev   = 1'b1;
            refill_ev = 1'b1;
            lat_start = 1'b1;
          end else begin
            fsm_nxt = IDLE;
          end
        end
        REFILL: begin
          if (icache_stall) begin
            refill_ev = 1'b1;
            lat_inc   = 1'b1;
          end else begin
            fsm_nxt  = IDLE;
            lat_done = 1'b1;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end else begin
      fsm_nxt = state;
    end
    state_nxt = clear ? IDLE : fsm_nxt;
  end

  // Post-edge counter values; clear wins over enable, and enable gates every increment.
  always_comb begin
    r_cyc    = sat_inc(cycles, enable);
    r_ret    = sat_inc(retired, enable & retire_valid);
    r_any    = sat_inc(any_stall, enable & ((|stall_req) | icache_stall));
    r_miss   = sat_inc(misses, miss_ev);
    r_refill = sat_inc(refill_cyc, refill_ev);
    ovf_set  = r_cyc[CNT_W] | r_ret[CNT_W] | r_any[CNT_W] | r_miss[CNT_W] | r_refill[CNT_W];
    for (int i = 0; i < NUM_STALL_SRC; i++) begin
      r_stall[i] = sat_inc(stall_cnt[i], enable & stall_req[i]);
      ovf_set    = ovf_set | r_stall[i][CNT_W];
    end

    if (clear) begin
      cycles_nxt     = '0;
      retired_nxt    = '0;
      any_stall_nxt  = '0;
      misses_nxt     = '0;
      refill_cyc_nxt = '0;
      for (int i = 0; i < NUM_STALL_SRC; i++) begin
        stall_cnt_nxt[i] = '0;
      end
      overflow_nxt = 1'b0;
    end else begin
      cycles_nxt     = r_cyc[CNT_W-1:0];
      retired_nxt    = r_ret[CNT_W-1:0];
      any_stall_nxt  = r_any[CNT_W-1:0];
      misses_nxt     = r_miss[CNT_W-1:0];
      refill_cyc_nxt = r_refill[CNT_W-1:0];
      for (int i = 0; i < NUM_STALL_SRC; i++) begin
        stall_cnt_nxt[i] = r_stall[i][CNT_W-1:0];
      end
      overflow_nxt = overflow | ovf_set;
    end

    if (clear) begin
      cur_lat_nxt = '0;
    end else if (lat_start) begin
      cur_lat_nxt = LAT_W'(1);
    end else if (lat_inc && !(&cur_lat)) begin
      cur_lat_nxt = cur_lat + LAT_W'(1);
    end else begin
      cur_lat_nxt = cur_lat;
    end

    if (clear) begin
      max_lat_nxt = '0;
    end else if (lat_done && (cur_lat > max_lat)) begin
      max_lat_nxt = cur_lat;
    end else begin
      max_lat_nxt = max_lat;
    end
  end

  // Readout mux over the post-edge values so rd_data trails rd_sel by exactly one edge.
  always_comb begin
    rd_vec[0] = cycles_nxt;
    rd_vec[1] = retired_nxt;
    rd_vec[2] = any_stall_nxt;
    rd_vec[3] = misses_nxt;
    rd_vec[4] = refill_cyc_nxt;
    rd_vec[5] = CNT_W'(max_lat_nxt);
    for (int i = 0; i < NUM_STALL_SRC; i++) begin
      rd_vec[6+i] = stall_cnt_nxt[i];
    end
    rd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next = rd_vec[i];
      end else begin
        rd_next = rd_next;
      end
    end
  end

  // Statistic registers and registered readout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles     <= '0;
      retired    <= '0;
      any_stall  <= '0;
      misses     <= '0;
      refill_cyc <= '0;
      for (int i = 0; i < NUM_STALL_SRC; i++) begin
        stall_cnt[i] <= '0;
      end
      cur_lat  <= '0;
      max_lat  <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      cycles     <= cycles_nxt;
      retired    <= retired_nxt;
      any_stall  <= any_stall_nxt;
      misses     <= misses_nxt;
      refill_cyc <= refill_cyc_nxt;
      for (int i = 0; i < NUM_STALL_SRC; i++) begin
        stall_cnt[i] <= stall_cnt_nxt[i];
      end
      cur_lat  <= cur_lat_nxt;
      max_lat  <= max_lat_nxt;
      overflow <= overflow_nxt;
      rd_data  <= rd_next;
    end
  end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a default-width instance for function checks
// and a 4-bit instance for saturation.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        reset, enable, clear;
  logic [2:0]  stall_req;
  logic        icache_stall, retire_valid;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data;
  logic        overflow;

  logic        reset_s, enable_s, clear_s;
  logic [3:0]  rd_data_s;
  logic        overflow_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .stall_req(stall_req), .icache_stall(icache_stall), .retire_valid(retire_valid),
    .rd_sel(rd_sel), .rd_data(rd_data), .overflow(overflow)
  );

  pipe_perf_monitor #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset_s), .enable(enable_s), .clear(clear_s),
    .stall_req(3'b000), .icache_stall(1'b0), .retire_valid(1'b0),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .overflow(overflow_s)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Select a counter while holding (enable low) and compare one edge later.
  task automatic read_chk(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    rd_sel = sel;
    tick(1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; stall_req = 3'b000;
    icache_stall = 1'b0; retire_valid = 1'b0; rd_sel = 4'd0;
    reset_s = 1'b0; enable_s = 1'b0; clear_s = 1'b0;

    // Reset overrides clear and enable.
    enable = 1'b1; clear = 1'b1;
    tick(2);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // Idle counting.
    reset = 1'b1; clear = 1'b0;
    tick(10);
    check("idle_cycles", rd_data, 32'd10);
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      read_chk($sformatf("idle_sel%0d", i), 4'(i), 32'd0);
    end
    check("idle_overflow", {31'd0, overflow}, 32'd0);
    read_chk("hold_cycles", 4'd0, 32'd10);

    // Miss latency: high 5, low 3, high 2, low 1.
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_reads_zero", rd_data, 32'd0);
    enable = 1'b1;
    icache_stall = 1'b1; tick(5);
    icache_stall = 1'b0; tick(3);
    icache_stall = 1'b1; tick(2);
    icache_stall = 1'b0; tick(1);
    enable = 1'b0;
    read_chk("miss_misses", 4'd3, 32'd2);
    read_chk("miss_refill", 4'd4, 32'd7);
    read_chk("miss_maxlat", 4'd5, 32'd5);
    read_chk("miss_anystall", 4'd2, 32'd7);
    read_chk("miss_cycles", 4'd0, 32'd11);

    // Per-source stalls.
    clear = 1'b1; tick(1); clear = 1'b0;
    enable = 1'b1;
    stall_req = 3'b101; tick(4);
    stall_req = 3'b010; tick(2);
    stall_req = 3'b000; enable = 1'b0;
    read_chk("stall0", 4'd6, 32'd4);
    read_chk("stall1", 4'd7, 32'd2);
    read_chk("stall2", 4'd8, 32'd4);
    read_chk("stall_any", 4'd2, 32'd6);
    read_chk("stall_misses", 4'd3, 32'd0);

    // Enable gating of RETIRED.
    clear = 1'b1; tick(1); clear = 1'b0;
    enable = 1'b1; retire_valid = 1'b1; tick(3);
    enable = 1'b0; tick(5);
    read_chk("retired_held", 4'd1, 32'd3);

    // Clear mid-miss: stall still high afterwards counts as a fresh miss.
    retire_valid = 1'b0; enable = 1'b1; icache_stall = 1'b1;
    rd_sel = 4'd3;
    tick(2);
    check("premiss_misses", rd_data, 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("midclear_misses", rd_data, 32'd0);
    tick(3);
    icache_stall = 1'b0; tick(1);
    enable = 1'b0;
    read_chk("postclear_misses", 4'd3, 32'd1);
    read_chk("postclear_maxlat", 4'd5, 32'd3);
    read_chk("postclear_refill", 4'd4, 32'd3);
    read_chk("postclear_retired", 4'd1, 32'd0);
    check("postclear_overflow", {31'd0, overflow}, 32'd0);

    // Readout latency and out-of-range selects.
    clear = 1'b1; tick(1); clear = 1'b0;
    enable = 1'b1; tick(5); enable = 1'b0;
    read_chk("lat_sel0", 4'd0, 32'd5);
    rd_sel = 4'd1;
    #1;
    check("lat_before_edge", rd_data, 32'd5);
    tick(1);
    check("lat_after_edge", rd_data, 32'd0);
    rd_sel = 4'd0; tick(1);
    read_chk("sel15", 4'd15, 32'd0);
    rd_sel = 4'd0; tick(1);
    read_chk("sel9", 4'd9, 32'd0);

    // Saturation on the 4-bit instance.
    rd_sel = 4'd0;
    reset_s = 1'b1; enable_s = 1'b1;
    tick(15);
    check("sat_at15_data", 32'(rd_data_s), 32'd15);
    check("sat_at15_ovf", {31'd0, overflow_s}, 32'd0);
    tick(1);
    check("sat_wrap_ovf", {31'd0, overflow_s}, 32'd1);
    tick(4);
    check("sat_20_data", 32'(rd_data_s), 32'd15);
    check("sat_20_ovf", {31'd0, overflow_s}, 32'd1);
    clear_s = 1'b1; tick(1); clear_s = 1'b0;
    check("sat_clear_data", 32'(rd_data_s), 32'd0);
    check("sat_clear_ovf", {31'd0, overflow_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Synthesizable performance-monitor unit that attaches to the cpu core and counts cycles, retired instructions, per-source stall cycles and instruction-cache miss events. It also measures icache refill latency, giving the total and the maximum. It generalises the cycle-by-cycle stall and hit/miss observation done in simulation into a parametrised hardware block. The block is read through a registered select/data port and feeds a future CSR or debug path.

Parameters:
CNT_W, 32, width of every event counter and of rd_data
NUM_STALL_SRC, 3, number of independent stall-request inputs (fetch, mem, hazard in the current core)
LAT_W, 16, width of the per-miss refill latency counter
SEL_W, 4, width of rd_sel; must satisfy 2^SEL_W >= 6 + NUM_STALL_SRC

Ports:
clk  in  1  core clock; all logic updates on its rising edge
reset  in  1  synchronous, active-low reset (block in reset while reset == 0)
enable  in  1  counting enable; when 0, all counters and the FSM hold
clear  in  1  synchronous clear pulse; zeroes all statistics
stall_req  in  NUM_STALL_SRC  per-source stall request, bit i = source i
icache_stall  in  1  icache refill in progress (high = miss being serviced)
retire_valid  in  1  one instruction retires this cycle
rd_sel  in  SEL_W  counter select for readout
rd_data  out  CNT_W  registered counter value selected by rd_sel on the previous edge
overflow  out  1  sticky; set when any counter saturates

Behaviour:
- Reset (reset == 0 at an edge):
  - all counters, cur_lat and max_lat go to 0; FSM goes to IDLE.
  - rd_data = 0 and overflow = 0.
  - Reset overrides clear and enable.
- Priority at each edge: reset > clear > enable.
- clear = 1:
  - same effect as reset on counters, FSM, cur_lat, max_lat and overflow.
  - rd_data still updates from the post-clear values, so it reads 0 on the next edge.
- enable = 0, clear = 0: every counter, the FSM and cur_lat hold their values; rd_data keeps updating.
- enable = 1, per edge:
  - sel 0 CYCLES: +1 every cycle.
  - sel 1 RETIRED: +1 if retire_valid.
  - sel 2 ANY_STALL: +1 if any bit of stall_req is set, or icache_stall is set.
  - sel 6+i STALL_i: +1 if stall_req[i] is set (i < NUM_STALL_SRC).
  - sel 3 MISSES, sel 4 REFILL_CYC and sel 5 MAX_LAT come from the FSM below.
  - rd_sel values above 5+NUM_STALL_SRC read 0.
- Refill FSM (states IDLE, REFILL), advances only when enabled:
  - IDLE with icache_stall = 1: go to REFILL; MISSES +1; cur_lat = 1; REFILL_CYC +1.
  - REFILL with icache_stall = 1: stay in REFILL; cur_lat +1 (saturates at 2^LAT_W-1); REFILL_CYC +1.
  - REFILL with icache_stall = 0: go to IDLE; max_lat = max(max_lat, cur_lat).
  - Back-to-back misses separated by a single low cycle count as 2 misses.
  - Latency counts the cycles icache_stall is high.
  - MAX_LAT reads max_lat zero-extended to CNT_W.
  - A stall still high when clear is applied counts as a new miss from the cycle after clear.
- Saturation: every CNT_W counter holds at all-ones and never wraps. The increment that would wrap sets overflow, which stays set until reset or clear.
- Readout: rd_data <= mux(rd_sel) of the counter values after this edge's update, giving a 1-cycle latency from rd_sel.
- A counter updated and read in the same cycle shows the updated value one cycle later.

Test Plan:
- Reset/idle: hold reset = 0 for 2 cycles, then release with enable = 1 and no events for 10 cycles -> rd_sel = 0 reads 10; rd_sel = 1..8 read 0; overflow = 0.
- Miss latency: icache_stall high for 5 cycles, low for 3, high for 2 -> MISSES = 2, REFILL_CYC = 7, MAX_LAT = 5.
- Per-source stalls: stall_req = 3'b101 for 4 cycles, then 3'b010 for 2 cycles -> STALL_0 = 4, STALL_1 = 2, STALL_2 = 4, ANY_STALL = 6.
- Enable/clear:
  - With enable = 0 for 5 cycles while retire_valid = 1 -> RETIRED unchanged.
  - Then clear = 1 mid-miss with icache_stall held high 3 more cycles -> after clear, MISSES = 1 and MAX_LAT = 3 once the stall drops.
- Saturation: run with CNT_W = 4 for 20 cycles -> CYCLES reads 15 and overflow = 1; the following clear gives CYCLES = 0 and overflow = 0.
- Out-of-range and latency: rd_sel = 15 -> rd_data = 0 on the next edge. Switch rd_sel 0 -> 1 -> rd_data changes exactly one edge later.
